// File: rtl/fc_layer_mac_seq_if.sv
// ---------------------------------------------------------------------------
// fc_layer_mac_seq_if
// Bus bundle for the sequential fully-connected layer.
//
// Signals:
//   start            request a new run; sampled only while the layer is idle
//   in_vector_flat   x[j] at [j*W +: W], signed
//   weights_flat     w[i][j] at [(i*IN_SIZE+j)*W +: W], signed
//   biases_flat      bias[i] at [i*W +: W], signed
//   out_vector_flat  out[i] at [i*W +: W], signed, registered
//   done             one-cycle pulse when every output is valid
//   busy             high while a run is in progress
//
// Modports:
//   master  the side that issues start, supplies operands and reads results
//   slave   the layer itself
// ---------------------------------------------------------------------------
interface fc_layer_mac_seq_if #(
    parameter int W        = 8,
    parameter int IN_SIZE  = 16,
    parameter int OUT_SIZE = 8
);
    logic                           start;
    logic [W*IN_SIZE-1:0]           in_vector_flat;
    logic [W*OUT_SIZE*IN_SIZE-1:0]  weights_flat;
    logic [W*OUT_SIZE-1:0]          biases_flat;
    logic [W*OUT_SIZE-1:0]          out_vector_flat;
    logic                           done;
    logic                           busy;

    modport master (
        output start, in_vector_flat, weights_flat, biases_flat,
        input  out_vector_flat, done, busy
    );

    modport slave (
        input  start, in_vector_flat, weights_flat, biases_flat,
        output out_vector_flat, done, busy
    );
endinterface

// File: rtl/fc_layer_mac_seq.sv
// ---------------------------------------------------------------------------
// fc_layer_mac_seq
// Sequential fully-connected layer:
//   out[i] = sat((bias[i] + sum_j w[i][j]*x[j]) >>> OUT_SHIFT)
// NUM_LANES MAC units work on one group of neurons at a time; groups are
// processed one after another (IN_SIZE MAC cycles + 1 write cycle each).
//
// Ports:
//   clk    rising-edge clock
//   reset  synchronous, active-high reset (aborts a run in progress)
//   bus    fc_layer_mac_seq_if.slave: start, flattened operands,
//          registered flattened results, done pulse, busy level
//
// Operands are read combinationally from the bus during the run; the
// driver must hold them stable from start acceptance until done.
//
// Build option:
//   FC_RELU_EN  when defined, negative saturated results are written as 0.
// ---------------------------------------------------------------------------
module fc_layer_mac_seq #(
    parameter int IN_SIZE   = 16,
    parameter int OUT_SIZE  = 8,
    parameter int W         = 8,
    parameter int ACC_WIDTH = 2*W+8,
    parameter int NUM_LANES = 1,
    parameter int OUT_SHIFT = 0
) (
    input  logic               clk,
    input  logic               reset,
    fc_layer_mac_seq_if.slave  bus
);

    localparam int JW = (IN_SIZE  > 1) ? $clog2(IN_SIZE)  : 1;
    localparam int NW = (OUT_SIZE > 1) ? $clog2(OUT_SIZE) : 1;

    localparam logic [JW-1:0] J_LAST    = JW'(IN_SIZE - 1);
    // Neuron base index of the final group; reaching it ends the run.
    localparam logic [NW-1:0] BASE_LAST = NW'(OUT_SIZE - NUM_LANES);
    localparam logic [NW-1:0] BASE_STEP = NW'(NUM_LANES);

    localparam logic signed [ACC_WIDTH-1:0] SAT_MAX = ACC_WIDTH'((1 << (W-1)) - 1);
    localparam logic signed [ACC_WIDTH-1:0] SAT_MIN = ~SAT_MAX;

    typedef enum logic [1:0] {ST_IDLE, ST_MAC, ST_WRITE, ST_DONE} state_t;

    state_t                 state_reg;
    logic [JW-1:0]          j_reg;
    logic [NW-1:0]          nbase_reg;   // first neuron of the current group
    logic                   done_reg;
    logic                   busy_reg;
    logic signed [W-1:0]    out_reg [OUT_SIZE];

    logic signed [W-1:0]    x_arr [IN_SIZE];
    logic signed [W-1:0]    w_arr [OUT_SIZE][IN_SIZE];
    logic signed [W-1:0]    b_arr [OUT_SIZE];
    logic signed [W-1:0]    lane_res [NUM_LANES];

    logic                   last_grp;
    logic                   acc_load;
    logic [NW-1:0]          load_base;

    // ---------------------------------------------------------------
    // Unpack the flattened buses into indexable arrays
    // ---------------------------------------------------------------
    genvar gi;
    generate
        for (gi = 0; gi < IN_SIZE; gi++) begin : g_x
            assign x_arr[gi] = bus.in_vector_flat[gi*W +: W];
        end
        for (gi = 0; gi < OUT_SIZE*IN_SIZE; gi++) begin : g_w
            assign w_arr[gi/IN_SIZE][gi%IN_SIZE] = bus.weights_flat[gi*W +: W];
        end
        for (gi = 0; gi < OUT_SIZE; gi++) begin : g_b
            assign b_arr[gi] = bus.biases_flat[gi*W +: W];
            assign bus.out_vector_flat[gi*W +: W] = out_reg[gi];
        end
    endgenerate

    assign bus.done = done_reg;
    assign bus.busy = busy_reg;

    assign last_grp = (nbase_reg == BASE_LAST);

    // Accumulators are (re)loaded with biases on start and between groups,
    // so the first MAC cycle of every group already sees bias in acc.
    assign acc_load = ((state_reg == ST_IDLE)  && bus.start) ||
                      ((state_reg == ST_WRITE) && !last_grp);

    // Base of the group whose biases are being loaded; only meaningful
    // while acc_load is high, held at 0 otherwise to stay in range.
    assign load_base = ((state_reg == ST_WRITE) && !last_grp) ? (nbase_reg + BASE_STEP) : '0;

    // ---------------------------------------------------------------
    // MAC lanes
    // ---------------------------------------------------------------
    generate
        for (gi = 0; gi < NUM_LANES; gi++) begin : g_lane
            logic [NW-1:0]                 nidx;
            logic [NW-1:0]                 lidx;
            logic signed [2*W-1:0]         prod;
            logic signed [ACC_WIDTH-1:0]   acc_reg;
            logic signed [ACC_WIDTH-1:0]   shifted;
            logic signed [ACC_WIDTH-1:0]   sat_val;

            assign nidx = nbase_reg + NW'(gi);
            assign lidx = load_base + NW'(gi);

            // Both operands are signed, so the multiply is evaluated at
            // 2W bits with sign extension: the full product, no wrap.
            assign prod = w_arr[nidx][j_reg] * x_arr[j_reg];

            always_ff @(posedge clk) begin
                if (reset) begin
                    acc_reg <= '0;
                end else if (acc_load) begin
                    acc_reg <= {{(ACC_WIDTH-W){b_arr[lidx][W-1]}}, b_arr[lidx]};
                end else if (state_reg == ST_MAC) begin
                    acc_reg <= acc_reg + {{(ACC_WIDTH-2*W){prod[2*W-1]}}, prod};
                end
            end

            // Arithmetic shift rounds toward minus infinity.
            assign shifted = acc_reg >>> OUT_SHIFT;

            always_comb begin
                sat_val = shifted;
                if (shifted > SAT_MAX) begin
                    sat_val = SAT_MAX;
                end else if (shifted < SAT_MIN) begin
                    sat_val = SAT_MIN;
                end
`ifdef FC_RELU_EN
                if (sat_val < 0) begin
                    sat_val = '0;
                end
`else
`endif
            end

            assign lane_res[gi] = sat_val[W-1:0];
        end
    endgenerate

    // ---------------------------------------------------------------
    // Control FSM with registered done/busy and result registers
    // ---------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= ST_IDLE;
            j_reg     <= '0;
            nbase_reg <= '0;
            done_reg  <= 1'b0;
            busy_reg  <= 1'b0;
            for (int i = 0; i < OUT_SIZE; i++) begin
                out_reg[i] <= '0;
            end
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    done_reg <= 1'b0;
                    if (bus.start) begin
                        state_reg <= ST_MAC;
                        j_reg     <= '0;
                        nbase_reg <= '0;
                        busy_reg  <= 1'b1;
                    end
                end
                ST_MAC: begin
                    if (j_reg == J_LAST) begin
                        j_reg     <= '0;
                        state_reg <= ST_WRITE;
                    end else begin
                        j_reg <= j_reg + JW'(1);
                    end
                end
                ST_WRITE: begin
                    for (int l = 0; l < NUM_LANES; l++) begin
                        out_reg[nbase_reg + NW'(l)] <= lane_res[l];
                    end
                    if (last_grp) begin
                        state_reg <= ST_DONE;
                        busy_reg  <= 1'b0;
                        done_reg  <= 1'b1;
                    end else begin
                        nbase_reg <= nbase_reg + BASE_STEP;
                        j_reg     <= '0;
                        state_reg <= ST_MAC;
                    end
                end
                ST_DONE: begin
                    // start is deliberately ignored here: no queuing.
                    done_reg  <= 1'b0;
                    state_reg <= ST_IDLE;
                end
                default: begin
                    state_reg <= ST_IDLE;
                    busy_reg  <= 1'b0;
                    done_reg  <= 1'b0;
                end
            endcase
        end
    end

endmodule
